if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the multistage MIPS datapath, directly upstream of the 4 KB instruction memory.
//  - Owns the PC register and drives pc to the IM.
//  - Takes the combinational instruction word back from the IM.
//  - Registers that word, with PC+4 and a valid bit, into the IF/ID pipeline register.
//  - Handles stall, branch/jump redirect and flush.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC after reset; IM indexes pc[11:2], so this maps to word 0
//  NOP_INSTR  32'h0000_0000  word loaded into IF/ID on a flush (sll $0,$0,0)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   synchronous reset, active low
//  stall        in   1   hazard unit: hold PC and IF/ID this cycle
//  redirect     in   1   ID stage: branch taken or jump; PC must leave sequential flow
//  redirect_sel in   2   00 branch, 01 j/jal, 10 jr/jalr, 11 reserved (treated as branch)
//  br_target    in   32  branch target computed in ID (id_pc4 + signext(imm)<<2)
//  j_index      in   26  instr[25:0] of the jump in ID
//  jr_addr      in   32  forwarded rs value for jr/jalr
//  im_instr     in   32  instruction word from IM for current pc (combinational)
//  pc           out  32  current fetch address to IM
//  id_instr     out  32  IF/ID instruction
//  id_pc4       out  32  IF/ID PC+4 of that instruction
//  id_valid     out  1   IF/ID holds a real (non-bubble) instruction
//  pc_misalign  out  1   sticky: a redirect target had addr[1:0]!=0
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge):
//    - pc=RESET_PC, id_instr=NOP_INSTR, id_pc4=0, id_valid=0, pc_misalign=0.
//    - Reset wins over every other input, including mid-stall or mid-redirect.
//  - Fetch latency: im_instr for pc appears at id_instr one clk later; pc advances one word per cycle when unobstructed.
//  - Next-PC:
//    - Sequential: pc+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0, no flag.
//    - Branch: br_target.
//    - j/jal: {id_pc4[31:28], j_index, 2'b00}, built from the registered id_pc4.
//    - jr/jalr: jr_addr.
//  - Misaligned redirect: the new pc has bits[1:0] forced to 00, and pc_misalign is set and stays 1 until reset.
//  - Priority per cycle: reset > redirect > stall > sequential.
//    - redirect=1 (regardless of stall): pc <= target; IF/ID flushed (id_instr<=NOP_INSTR, id_valid<=0, id_pc4<=0).
//      The word fetched this cycle is discarded; one delay-slot bubble, no architectural delay slot.
//    - stall=1, redirect=0: pc, id_instr, id_pc4, id_valid all hold. im_instr is ignored.
//    - Neither: pc <= pc+4; id_instr <= im_instr; id_pc4 <= pc+4; id_valid <= 1.
//  - Back-to-back redirects each take effect the cycle they are asserted; only the last one wins for pc.
//  - Stall held N cycles: exactly one IF/ID load occurs after release, and no instruction is skipped or duplicated.
//  - All outputs are registered; no combinational path from any input to any output.
// STRUCTURE
//  - Shared include npc_defs.vh holds:
//    - NPC_BR=2'b00, NPC_J=2'b01, NPC_JR=2'b10.
//    - RESET_PC and NOP_INSTR defaults.
//    These are reused by the control unit that drives redirect_sel.
//  - One sub-module: if_id_reg. It holds id_instr/id_pc4/id_valid with load, flush and hold controls; flush beats hold.
//  - Next-PC mux and the PC register live in the top module.
// TESTING
//  1 Reset: rst_n=0 two cycles, then 1 with IM word0=32'h2008_0005 -> pc=3000; next cycle pc=3004, id_instr=20080005, id_pc4=3004, id_valid=1.
//  2 Stall: stall=1 for 3 cycles at pc=3008 -> pc stays 3008, IF/ID unchanged. Release -> id_instr=IM[2], then IM[3], with no skip or duplicate.
//  3 Jump: at id_pc4=3010, redirect=1, sel=01, j_index=26'h0000C10 -> pc=00003040, id_valid=0 next cycle; following cycle id_instr=IM[0x10].
//  4 Redirect during stall: stall=1, redirect=1, sel=00, br_target=3100 -> pc=3100 and IF/ID flushed (redirect wins).
//  5 jr misaligned: sel=10, jr_addr=32'h0000_3206 -> pc=3204, pc_misalign=1, and it stays 1 through later redirects until rst_n=0.
//  6 Wrap, checked with the RESET_PC override: RESET_PC=32'hFFFF_FFFC -> pc goes FFFFFFFC then 00000000; id_pc4=0. Then reset mid-stall -> all outputs return to reset values.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared next-PC selector encodings and fetch-stage reset defaults, also used by
// the control unit that drives redirect_sel.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    NPC_BR  = 2'b00,
    NPC_J   = 2'b01,
    NPC_JR  = 2'b10,
    NPC_RSV = 2'b11
  } npc_sel_e;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  logic [31:0] instr_d, instr_q;
  logic [31:0] pc4_d, pc4_q;
  logic        valid_d, valid_q;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (hold) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else if (load) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign id_instr = instr_q;
  assign id_pc4   = pc4_q;
  assign id_valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC mux and IF/ID register.
// Every output comes straight from a flop.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [1:0]  redirect_sel,
  input  logic [31:0] br_target,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        pc_misalign
);

  logic [31:0] pc_d, pc_q;
  logic        misalign_d, misalign_q;
  logic [31:0] pc_seq;
  logic [31:0] redir_tgt;

  // Jump region comes from the registered id_pc4, i.e. the jump's own PC+4.
  always_comb begin
    pc_seq = pc_q + 32'd4;
    case (npc_sel_e'(redirect_sel))
      NPC_J:   redir_tgt = {id_pc4[31:28], j_index, 2'b00};
      NPC_JR:  redir_tgt = jr_addr;
      default: redir_tgt = br_target;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (redirect) begin
      pc_d       = {redir_tgt[31:2], 2'b00};
      misalign_d = misalign_q | is_misaligned(redir_tgt);
    end else if (!stall) begin
      pc_d = pc_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .hold     (stall),
    .load     (1'b1),
    .instr_in (im_instr),
    .pc4_in   (pc_seq),
    .id_instr (id_instr),
    .id_pc4   (id_pc4),
    .id_valid (id_valid)
  );

  assign pc          = pc_q;
  assign pc_misalign = misalign_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random stall/redirect traffic
// against a next-state reference model; a second instance covers PC wrap.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [1:0]  redirect_sel;
  logic [31:0] br_target, jr_addr, im_instr;
  logic [25:0] j_index;
  logic [31:0] pc, id_instr, id_pc4;
  logic        id_valid, pc_misalign;

  logic        rst_n_w, stall_w, redirect_w;
  logic [31:0] im_instr_w, pc_w, id_instr_w, id_pc4_w;
  logic        id_valid_w, pc_misalign_w;

  logic [31:0] mem [1024];

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_mis;

  always #5 clk = ~clk;

  assign im_instr   = mem[pc[11:2]];
  assign im_instr_w = mem[pc_w[11:2]];

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_sel(redirect_sel), .br_target(br_target), .j_index(j_index),
    .jr_addr(jr_addr), .im_instr(im_instr), .pc(pc), .id_instr(id_instr),
    .id_pc4(id_pc4), .id_valid(id_valid), .pc_misalign(pc_misalign)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n_w), .stall(stall_w), .redirect(redirect_w),
    .redirect_sel(2'b00), .br_target(32'h0), .j_index(26'h0),
    .jr_addr(32'h0), .im_instr(im_instr_w), .pc(pc_w), .id_instr(id_instr_w),
    .id_pc4(id_pc4_w), .id_valid(id_valid_w), .pc_misalign(pc_misalign_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: apply the per-cycle priority rules, then advance one clock and compare.
  task automatic step(input logic r, input logic s, input logic rd, input logic [1:0] sel,
                      input logic [31:0] bt, input logic [25:0] ji, input logic [31:0] ja);
    logic [31:0] tgt;
    rst_n = r; stall = s; redirect = rd; redirect_sel = sel;
    br_target = bt; j_index = ji; jr_addr = ja;
    if (!r) begin
      m_pc = 32'h3000; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    end else if (rd) begin
      if (sel == 2'b01)      tgt = (m_pc4 & 32'hF000_0000) | (32'(ji) * 4);
      else if (sel == 2'b10) tgt = ja;
      else                   tgt = bt;
      if (tgt % 4 != 0) m_mis = 1'b1;
      m_pc = tgt - (tgt % 4);
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!s) begin
      m_instr = mem[(m_pc / 4) % 1024];
      m_pc    = m_pc + 4;
      m_pc4   = m_pc;
      m_valid = 1'b1;
    end
    @(posedge clk); #1;
    chk("pc", pc, m_pc);
    chk("id_instr", id_instr, m_instr);
    chk("id_pc4", id_pc4, m_pc4);
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    chk("pc_misalign", 32'(pc_misalign), 32'(m_mis));
  endtask

  task automatic run(input logic s);
    step(1'b1, s, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sel;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0005;
    rst_n_w = 1'b0; stall_w = 1'b0; redirect_w = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;

    // reset, then first fetch
    step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 2'b01, 32'h5, 26'h1, 32'h7);
    chk("rst_pc", pc, 32'h3000);
    run(1'b0);
    chk("first_pc", pc, 32'h3004);
    chk("first_instr", id_instr, 32'h2008_0005);
    chk("first_pc4", id_pc4, 32'h3004);
    run(1'b0);

    // stall three cycles at 3008
    run(1'b1); run(1'b1); run(1'b1);
    chk("stall_pc", pc, 32'h3008);
    chk("stall_instr", id_instr, mem[1]);
    run(1'b0);
    chk("rel_instr2", id_instr, mem[2]);
    run(1'b0);
    chk("rel_instr3", id_instr, mem[3]);
    chk("rel_pc4", id_pc4, 32'h3010);

    // jump
    step(1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 26'h000_0C10, 32'h0);
    chk("j_pc", pc, 32'h3040);
    chk("j_valid", 32'(id_valid), 32'h0);
    run(1'b0);
    chk("j_instr", id_instr, mem[16]);

    // redirect during stall
    step(1'b1, 1'b1, 1'b1, 2'b00, 32'h3100, 26'h0, 32'h0);
    chk("rs_pc", pc, 32'h3100);
    chk("rs_valid", 32'(id_valid), 32'h0);

    // misaligned jr, sticky through later redirects
    step(1'b1, 1'b0, 1'b1, 2'b10, 32'h0, 26'h0, 32'h3206);
    chk("jr_pc", pc, 32'h3204);
    chk("jr_mis", 32'(pc_misalign), 32'h1);
    step(1'b1, 1'b0, 1'b1, 2'b11, 32'h3300, 26'h0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 2'b00, 32'h3400, 26'h0, 32'h0);
    run(1'b0);
    chk("mis_sticky", 32'(pc_misalign), 32'h1);

    // back-to-back redirects: last wins
    step(1'b1, 1'b0, 1'b1, 2'b00, 32'h3500, 26'h0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 2'b10, 32'h0, 26'h0, 32'h3600);
    chk("b2b_pc", pc, 32'h3600);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      a = 32'h3000 + 32'($urandom_range(0, 1023)) * 4;
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      sel = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 6) == 0), sel, a, 26'($urandom), a ^ 32'h4);
    end

    // wrap instance: FFFFFFFC -> 0, then reset mid-stall
    rst_n = 1'b1; stall = 1'b1; redirect = 1'b0;
    rst_n_w = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("w_rst_pc", pc_w, 32'hFFFF_FFFC);
    rst_n_w = 1'b1;
    @(posedge clk); #1;
    chk("w_pc", pc_w, 32'h0);
    chk("w_pc4", id_pc4_w, 32'h0);
    chk("w_instr", id_instr_w, mem[1023]);
    chk("w_valid", 32'(id_valid_w), 32'h1);
    stall_w = 1'b1;
    @(posedge clk); #1;
    chk("w_stall_pc", pc_w, 32'h0);
    chk("w_stall_valid", 32'(id_valid_w), 32'h1);
    rst_n_w = 1'b0;
    @(posedge clk); #1;
    chk("w_rs_pc", pc_w, 32'hFFFF_FFFC);
    chk("w_rs_instr", id_instr_w, 32'h0);
    chk("w_rs_pc4", id_pc4_w, 32'h0);
    chk("w_rs_valid", 32'(id_valid_w), 32'h0);
    chk("w_rs_mis", 32'(pc_misalign_w), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
